hamming_decoder: RTL and testbench



---
 rtl/hamming_decoder.sv | 127 ++++++++++++
 tb/tb_hamming_decoder.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/hamming_decoder.sv
// Two-stage SECDED decoder for extended-Hamming codewords on a valid/ready stream.
// Stage 1 registers the syndrome and overall parity. Stage 2 registers the corrected payload and flags.
module hamming_decoder #(
  parameter int DATA_WIDTH   = 32,
  parameter int COUNT_WIDTH  = 16,
  localparam int ADDR_WIDTH  = $clog2(DATA_WIDTH + 1 + $clog2(DATA_WIDTH + 1 + $clog2(DATA_WIDTH + 1))),
  localparam int CODED_WIDTH = DATA_WIDTH + ADDR_WIDTH + 1
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   valid_i,
  output logic                   ready_o,
  input  logic [CODED_WIDTH-1:0] data_in_i,
  output logic                   valid_o,
  input  logic                   ready_i,
  output logic [DATA_WIDTH-1:0]  data_o,
  output logic                   corrected_o,
  output logic                   uncorrectable_o,
  output logic [ADDR_WIDTH-1:0]  syndrome_o,
  input  logic                   clear_counts_i,
  output logic [COUNT_WIDTH-1:0] corrected_count_o,
  output logic [COUNT_WIDTH-1:0] uncorrectable_count_o
);

  logic                   s1_valid;
  logic [CODED_WIDTH-1:0] s1_cw;
  logic [ADDR_WIDTH-1:0]  s1_syn;
  logic                   s1_par;

  logic [ADDR_WIDTH-1:0]  syn_c;
  logic                   par_c;
  logic [CODED_WIDTH-1:0] cw_fix;
  logic [DATA_WIDTH-1:0]  data_c;
  logic                   corr_c;
  logic                   unc_c;

  logic s1_load;
  logic s2_load;
  logic out_fire;

  assign ready_o  = !s1_valid || !valid_o || ready_i;
  assign s1_load  = valid_i && ready_o;
  assign s2_load  = s1_valid && (!valid_o || ready_i);
  assign out_fire = valid_o && ready_i;

  always_comb begin
    syn_c = '0;
    for (int unsigned k = 1; k < CODED_WIDTH; k++) begin
      if (data_in_i[k]) syn_c = syn_c ^ ADDR_WIDTH'(k);
    end
    par_c = ^data_in_i;
  end

  // A nonzero syndrome beyond the codeword is unreachable by one flip, so it is uncorrectable.
  always_comb begin
    corr_c = s1_par && (int'(s1_syn) < CODED_WIDTH);
    unc_c  = (s1_syn != '0) && !corr_c;
    cw_fix = s1_cw;
    if (corr_c && (s1_syn != '0)) cw_fix[s1_syn] = ~s1_cw[s1_syn];
  end

  always_comb begin
    int unsigned j;
    data_c = '0;
    j      = 0;
    for (int unsigned k = 3; k < CODED_WIDTH; k++) begin
      if ((k & (k - 1)) != 0) begin
        if (j < DATA_WIDTH) data_c[j] = cw_fix[k];
        j++;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      s1_valid <= 1'b0;
      s1_cw    <= '0;
      s1_syn   <= '0;
      s1_par   <= 1'b0;
    end else begin
      if (s1_load) begin
        s1_valid <= 1'b1;
        s1_cw    <= data_in_i;
        s1_syn   <= syn_c;
        s1_par   <= par_c;
      end else if (s2_load) begin
        s1_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      valid_o         <= 1'b0;
      data_o          <= '0;
      corrected_o     <= 1'b0;
      uncorrectable_o <= 1'b0;
      syndrome_o      <= '0;
    end else begin
      if (s2_load) begin
        valid_o         <= 1'b1;
        data_o          <= data_c;
        corrected_o     <= corr_c;
        uncorrectable_o <= unc_c;
        syndrome_o      <= s1_syn;
      end else if (ready_i) begin
        valid_o <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      corrected_count_o     <= '0;
      uncorrectable_count_o <= '0;
    end else if (clear_counts_i) begin
      corrected_count_o     <= '0;
      uncorrectable_count_o <= '0;
    end else if (out_fire) begin
      if (corrected_o && (corrected_count_o != '1))
        corrected_count_o <= corrected_count_o + 1'b1;
      if (uncorrectable_o && (uncorrectable_count_o != '1))
        uncorrectable_count_o <= uncorrectable_count_o + 1'b1;
    end
  end

endmodule

// File: tb/tb_hamming_decoder.sv
// Directed bench for hamming_decoder: vector table, backpressure stream, counter saturation/clear, mid-stream reset.
module tb_hamming_decoder;

  localparam int CW = 39;
  localparam int DW = 32;

  typedef struct {
    logic [CW-1:0] cw;
    logic [DW-1:0] data;
    logic          corr;
    logic          unc;
    logic [5:0]    syn;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          valid_i, ready_o, valid_o, ready_i, corrected_o, uncorrectable_o, clear_counts_i;
  logic [CW-1:0] data_in_i;
  logic [DW-1:0] data_o;
  logic [5:0]    syndrome_o;
  logic [15:0]   corrected_count_o, uncorrectable_count_o;

  logic          v2, r2o, vo2, r2, co2, uo2, clr2;
  logic [CW-1:0] d2;
  logic [DW-1:0] do2;
  logic [5:0]    so2;
  logic [1:0]    cc2, uc2;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  hamming_decoder dut (
    .clk_i(clk), .rst_n_i(rst_n), .valid_i(valid_i), .ready_o(ready_o), .data_in_i(data_in_i),
    .valid_o(valid_o), .ready_i(ready_i), .data_o(data_o), .corrected_o(corrected_o),
    .uncorrectable_o(uncorrectable_o), .syndrome_o(syndrome_o), .clear_counts_i(clear_counts_i),
    .corrected_count_o(corrected_count_o), .uncorrectable_count_o(uncorrectable_count_o)
  );

  hamming_decoder #(.COUNT_WIDTH(2)) dut2 (
    .clk_i(clk), .rst_n_i(rst_n), .valid_i(v2), .ready_o(r2o), .data_in_i(d2),
    .valid_o(vo2), .ready_i(r2), .data_o(do2), .corrected_o(co2),
    .uncorrectable_o(uo2), .syndrome_o(so2), .clear_counts_i(clr2),
    .corrected_count_o(cc2), .uncorrectable_count_o(uc2)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [CW-1:0] encode(input logic [DW-1:0] d);
    logic [CW-1:0] c;
    int unsigned   j;
    c = '0;
    j = 0;
    for (int k = 3; k < CW; k++) begin
      if ((k & (k - 1)) != 0) begin
        c[k] = d[j];
        j++;
      end
    end
    for (int i = 0; i < 6; i++) begin
      logic p;
      p = 1'b0;
      for (int k = 1; k < CW; k++) if (((k >> i) & 1) != 0) p = p ^ c[k];
      c[1 << i] = p;
    end
    c[0] = ^c[CW-1:1];
    return c;
  endfunction

  function automatic logic [CW-1:0] bit_at(input int pos);
    logic [CW-1:0] b;
    b = '0;
    b[pos] = 1'b1;
    return b;
  endfunction

  task automatic send_one(input vec_t v, input string nm);
    valid_i   = 1'b1;
    data_in_i = v.cw;
    ready_i   = 1'b1;
    @(negedge clk);
    valid_i = 1'b0;
    chk({nm, "_lat1"}, valid_o, 1'b0);
    @(negedge clk);
    chk({nm, "_valid"}, valid_o, 1'b1);
    chk({nm, "_data"}, data_o, v.data);
    chk({nm, "_syn"}, syndrome_o, v.syn);
    chk({nm, "_flags"}, {corrected_o, uncorrectable_o}, {v.corr, v.unc});
    @(negedge clk);
  endtask

  task automatic send2(input logic [CW-1:0] cw, input logic clr);
    v2 = 1'b1;
    d2 = cw;
    @(negedge clk);
    v2 = 1'b0;
    @(negedge clk);
    clr2 = clr;
    @(negedge clk);
    clr2 = 1'b0;
  endtask

  vec_t          tbl[10];
  logic [CW-1:0] scw[8];
  logic [DW-1:0] sd[8];
  int            exp_corr, exp_unc;

  initial begin
    int   idx_in, idx_out, cyc;
    logic held, saw_full;
    logic [DW+7:0] held_val;
    vec_t v;

    tbl[0] = '{39'h0, 32'h0, 1'b0, 1'b0, 6'd0};
    tbl[1] = '{bit_at(5), 32'h0, 1'b1, 1'b0, 6'd5};
    tbl[2] = '{bit_at(0), 32'h0, 1'b1, 1'b0, 6'd0};
    tbl[3] = '{bit_at(3) | bit_at(5), 32'h3, 1'b0, 1'b1, 6'd6};
    tbl[4] = '{bit_at(32) | bit_at(8) | bit_at(1), 32'h0, 1'b0, 1'b1, 6'd41};
    tbl[5] = '{encode(32'hDEADBEEF) ^ bit_at(38), 32'hDEADBEEF, 1'b1, 1'b0, 6'd38};
    tbl[6] = '{encode(32'hDEADBEEF), 32'hDEADBEEF, 1'b0, 1'b0, 6'd0};
    tbl[7] = '{encode(32'h12345678) ^ bit_at(0), 32'h12345678, 1'b1, 1'b0, 6'd0};
    tbl[8] = '{encode(32'hFFFFFFFF) ^ bit_at(7) ^ bit_at(20), 32'hFFFFBFF7, 1'b0, 1'b1, 6'd19};
    tbl[9] = '{encode(32'hA5A5A5A5) ^ bit_at(1), 32'hA5A5A5A5, 1'b1, 1'b0, 6'd1};
    for (int k = 0; k < 8; k++) begin
      sd[k]  = (k * 32'h01234567) ^ 32'h89ABCDEF;
      scw[k] = encode(sd[k]) ^ bit_at(1 + (k * 5) % 38);
    end

    rst_n = 1'b0; valid_i = 1'b0; ready_i = 1'b1; data_in_i = '0; clear_counts_i = 1'b0;
    v2 = 1'b0; r2 = 1'b1; d2 = '0; clr2 = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_outputs", {valid_o, data_o, corrected_o, uncorrectable_o, syndrome_o}, '0);
    chk("rst_counts", {corrected_count_o, uncorrectable_count_o}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", ready_o, 1'b1);

    exp_corr = 0;
    exp_unc  = 0;
    for (int i = 0; i < 10; i++) begin
      send_one(tbl[i], $sformatf("vec%0d", i));
      exp_corr += int'(tbl[i].corr);
      exp_unc  += int'(tbl[i].unc);
    end
    chk("tbl_corr_count", corrected_count_o, 16'(exp_corr));
    chk("tbl_unc_count", uncorrectable_count_o, 16'(exp_unc));

    idx_in = 0; idx_out = 0; cyc = 0; held = 1'b0; saw_full = 1'b0; held_val = '0;
    while (idx_out < 8 && cyc < 200) begin
      if (held) chk("stall_hold", {valid_o, corrected_o, syndrome_o, data_o}, held_val);
      held    = 1'b0;
      ready_i = !(cyc >= 3 && cyc <= 6);
      valid_i = (idx_in < 8);
      data_in_i = (idx_in < 8) ? scw[idx_in] : '0;
      #1;
      if (valid_o && !ready_o) saw_full = 1'b1;
      if (valid_o && ready_i) begin
        chk($sformatf("stream%0d", idx_out), {corrected_o, data_o}, {1'b1, sd[idx_out]});
        idx_out++;
      end else if (valid_o) begin
        held     = 1'b1;
        held_val = {valid_o, corrected_o, syndrome_o, data_o};
      end
      if (valid_i && ready_o) idx_in++;
      @(negedge clk);
      cyc++;
    end
    valid_i = 1'b0;
    ready_i = 1'b1;
    chk("stream_done", idx_out, 8);
    chk("stream_ready_drop", saw_full, 1'b1);
    exp_corr += 8;
    @(negedge clk);
    chk("stream_corr_count", corrected_count_o, 16'(exp_corr));

    ready_i = 1'b0;
    valid_i = 1'b1;
    data_in_i = encode(32'hCAFEF00D) ^ bit_at(9);
    cyc = 0;
    while (!(valid_o && !ready_o) && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk("fill_before_reset", {valid_o, ready_o}, 2'b10);
    valid_i = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", valid_o, 1'b0);
    chk("midrst_counts", {corrected_count_o, uncorrectable_count_o}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    v = '{encode(32'h0BADF00D), 32'h0BADF00D, 1'b0, 1'b0, 6'd0};
    send_one(v, "post_rst");

    for (int k = 0; k < 5; k++) begin
      send2(encode(32'h100 + k) ^ bit_at(3), 1'b0);
      if (k == 1) chk("sat_two", cc2, 2'd2);
    end
    chk("sat_count", cc2, 2'd3);
    send2(encode(32'h55) ^ bit_at(12), 1'b1);
    chk("clear_wins", cc2, 2'd0);
    send2(encode(32'h66) ^ bit_at(12), 1'b0);
    chk("after_clear", cc2, 2'd1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
